max_pool_grad: RTL

//  Backward pass of the max-pool layer: routes each upstream gradient from the pooled grid

---
 rtl/dnn_pkg.sv | 27 ++
 rtl/act_memory.sv | 42 ++++
 rtl/pool_window_counter.sv | 84 ++++++++
 rtl/max_pool_grad.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_pkg.sv
// Shared types and floating-point helpers for the DNN layer blocks.
package dnn_pkg;

  typedef logic [15:0] index_t;
  typedef index_t [2:0] idx3_t;  // [2]=entry [1]=y [0]=x

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCAN_ISSUE,
    SCAN_CMP,
    GRAD_READ,
    ACC_READ,
    WRITE,
    DONE
  } state_t;

  // NaN on either side compares false, so a NaN can never displace the running max.
  function automatic logic real_gt(input logic [63:0] a, input logic [63:0] b);
    return $bitstoreal(a) > $bitstoreal(b);
  endfunction

  function automatic logic [63:0] real_add(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) + $bitstoreal(b));
  endfunction

endpackage

// File: rtl/act_memory.sv
// Activation/gradient word store addressed by (entry, y, x); one write port,
// one read port whose data is valid the cycle after the read index is registered.
module act_memory
  import dnn_pkg::*;
#(
  parameter string NAME       = "ACT_MEMORY",
  parameter int    NUM_INPUTS = 16,
  parameter int    DIM        = 26,
  parameter int    DATA_SIZE  = 64
) (
  input  logic                 clk,
  input  logic                 write_en_i,
  input  logic [DATA_SIZE-1:0] write_data_i,
  input  idx3_t                write_index_i,
  input  idx3_t                read_index_i,
  output logic [DATA_SIZE-1:0] read_data_o
);

  localparam int DEPTH = NUM_INPUTS * DIM * DIM;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (NAME == "") begin : g_name_chk
    $error("act_memory instance requires a non-empty NAME");
  end

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  idx3_t                rd_index_q;

  function automatic logic [AW-1:0] flat_addr(input idx3_t idx);
    return AW'((32'(idx[2]) * DIM + 32'(idx[1])) * DIM + 32'(idx[0]));
  endfunction

  always_ff @(posedge clk) begin
    if (write_en_i) begin
      mem_q[flat_addr(write_index_i)] <= write_data_i;
    end
    rd_index_q <= read_index_i;
  end

  assign read_data_o = mem_q[flat_addr(rd_index_q)];

endmodule

// File: rtl/pool_window_counter.sv
// Walks pooling windows (entry/oy/ox) and the kernel offset k inside each window.
module pool_window_counter
  import dnn_pkg::*;
#(
  parameter int NUM_INPUTS = 16,
  parameter int OUTPUT_DIM = 13,
  parameter int KERNEL_DIM = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clr_i,
  input  logic   k_adv_i,
  input  logic   win_adv_i,
  output index_t e_o,
  output index_t oy_o,
  output index_t ox_o,
  output index_t k_o,
  output logic   k_last_o,
  output logic   win_last_o
);

  index_t e_q, e_d, oy_q, oy_d, ox_q, ox_d, k_q, k_d;
  logic   e_last, oy_last, ox_last;

  assign e_last     = (e_q == index_t'(NUM_INPUTS - 1));
  assign oy_last    = (oy_q == index_t'(OUTPUT_DIM - 1));
  assign ox_last    = (ox_q == index_t'(OUTPUT_DIM - 1));
  assign k_last_o   = (k_q == index_t'(KERNEL_DIM * KERNEL_DIM - 1));
  assign win_last_o = e_last && oy_last && ox_last;

  assign e_o  = e_q;
  assign oy_o = oy_q;
  assign ox_o = ox_q;
  assign k_o  = k_q;

  // Window advance is raster ox -> oy -> entry and wraps to zero after the last window.
  always_comb begin
    e_d  = e_q;
    oy_d = oy_q;
    ox_d = ox_q;
    k_d  = k_q;
    if (win_adv_i) begin
      k_d = '0;
      if (ox_last) begin
        ox_d = '0;
        if (oy_last) begin
          oy_d = '0;
          if (e_last) begin
            e_d = '0;
          end else begin
            e_d = e_q + 16'd1;
          end
        end else begin
          oy_d = oy_q + 16'd1;
        end
      end else begin
        ox_d = ox_q + 16'd1;
      end
    end else if (k_adv_i) begin
      if (k_last_o) begin
        k_d = '0;
      end else begin
        k_d = k_q + 16'd1;
      end
    end else begin
      k_d = k_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      e_q  <= '0;
      oy_q <= '0;
      ox_q <= '0;
      k_q  <= '0;
    end else begin
      e_q  <= e_d;
      oy_q <= oy_d;
      ox_q <= ox_d;
      k_q  <= k_d;
    end
  end

endmodule

// File: rtl/max_pool_grad.sv
// Max-pool backward pass: routes each pooled gradient to the argmax of its window.
// Define MAXPOOL_GRAD_ACCUM_EN to accumulate into the input-gradient memory (overlapping windows).
module max_pool_grad
  import dnn_pkg::*;
#(
  parameter string NAME       = "MAXPOOL_GRAD_DEFAULT_NAME",
  parameter int    NUM_INPUTS = 16,
  parameter int    INPUT_DIM  = 26,
  parameter int    KERNEL_DIM = 2,
  parameter int    DATA_SIZE  = 64,
  parameter int    STRIDE     = KERNEL_DIM,
  parameter int    OUTPUT_DIM = (INPUT_DIM - KERNEL_DIM) / STRIDE + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 act_want_write,
  input  logic [DATA_SIZE-1:0] act_write_data,
  input  idx3_t                act_write_index,
  input  logic                 grad_want_write,
  input  logic [DATA_SIZE-1:0] grad_write_data,
  input  idx3_t                grad_write_index,
  input  idx3_t                outmem_read_index,
  output logic [DATA_SIZE-1:0] read_data,
  input  logic                 compute,
  output logic                 output_valid
);

`ifndef MAXPOOL_GRAD_ACCUM_EN
  if (STRIDE < KERNEL_DIM) begin : g_stride_chk
    $error("max_pool_grad: overlapping windows need MAXPOOL_GRAD_ACCUM_EN");
  end
`endif

  state_t               state_q, state_d;
  idx3_t                clr_q, clr_d;
  idx3_t                argmax_q, argmax_d;
  logic [DATA_SIZE-1:0] max_q, max_d;
  logic [DATA_SIZE-1:0] grad_q, grad_d;
  logic                 phase_q, phase_d;
  logic                 valid_q;

  index_t e, oy, ox, k;
  logic   k_last, win_last, cnt_clr, k_adv, win_adv;

  idx3_t                scan_idx, grad_idx, out_ridx, out_widx;
  logic [DATA_SIZE-1:0] act_rdata, grad_rdata, out_rdata, out_wdata;
  logic                 out_we, clr_last;

  pool_window_counter #(
    .NUM_INPUTS(NUM_INPUTS),
    .OUTPUT_DIM(OUTPUT_DIM),
    .KERNEL_DIM(KERNEL_DIM)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (cnt_clr),
    .k_adv_i   (k_adv),
    .win_adv_i (win_adv),
    .e_o       (e),
    .oy_o      (oy),
    .ox_o      (ox),
    .k_o       (k),
    .k_last_o  (k_last),
    .win_last_o(win_last)
  );

  assign scan_idx[2] = e;
  assign scan_idx[1] = index_t'(32'(oy) * STRIDE + 32'(k) / KERNEL_DIM);
  assign scan_idx[0] = index_t'(32'(ox) * STRIDE + 32'(k) % KERNEL_DIM);
  assign grad_idx[2] = e;
  assign grad_idx[1] = oy;
  assign grad_idx[0] = ox;

  assign out_ridx = (state_q == IDLE || state_q == DONE) ? outmem_read_index : argmax_q;
  assign clr_last = (clr_q[2] == index_t'(NUM_INPUTS - 1)) &&
                    (clr_q[1] == index_t'(INPUT_DIM - 1)) &&
                    (clr_q[0] == index_t'(INPUT_DIM - 1));

  act_memory #(
    .NAME({NAME, "_ACT"}), .NUM_INPUTS(NUM_INPUTS), .DIM(INPUT_DIM), .DATA_SIZE(DATA_SIZE)
  ) u_act_mem (
    .clk          (clk),
    .write_en_i   (act_want_write),
    .write_data_i (act_write_data),
    .write_index_i(act_write_index),
    .read_index_i (scan_idx),
    .read_data_o  (act_rdata)
  );

  act_memory #(
    .NAME({NAME, "_GRAD"}), .NUM_INPUTS(NUM_INPUTS), .DIM(OUTPUT_DIM), .DATA_SIZE(DATA_SIZE)
  ) u_grad_mem (
    .clk          (clk),
    .write_en_i   (grad_want_write),
    .write_data_i (grad_write_data),
    .write_index_i(grad_write_index),
    .read_index_i (grad_idx),
    .read_data_o  (grad_rdata)
  );

  act_memory #(
    .NAME({NAME, "_OUT"}), .NUM_INPUTS(NUM_INPUTS), .DIM(INPUT_DIM), .DATA_SIZE(DATA_SIZE)
  ) u_out_mem (
    .clk          (clk),
    .write_en_i   (out_we),
    .write_data_i (out_wdata),
    .write_index_i(out_widx),
    .read_index_i (out_ridx),
    .read_data_o  (out_rdata)
  );

  assign read_data    = out_rdata;
  assign output_valid = valid_q;

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    argmax_d  = argmax_q;
    max_d     = max_q;
    grad_d    = grad_q;
    phase_d   = phase_q;
    cnt_clr   = 1'b0;
    k_adv     = 1'b0;
    win_adv   = 1'b0;
    out_we    = 1'b0;
    out_widx  = argmax_q;
    out_wdata = '0;
    case (state_q)
      IDLE: begin
        if (compute) begin
          state_d = CLEAR;
          clr_d   = '0;
          cnt_clr = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        // Zero every location so positions outside any window read back as 0.
        out_we   = 1'b1;
        out_widx = clr_q;
        if (clr_last) begin
          clr_d   = '0;
          state_d = SCAN_ISSUE;
        end else if (clr_q[0] == index_t'(INPUT_DIM - 1)) begin
          clr_d[0] = '0;
          if (clr_q[1] == index_t'(INPUT_DIM - 1)) begin
            clr_d[1] = '0;
            clr_d[2] = clr_q[2] + 16'd1;
          end else begin
            clr_d[1] = clr_q[1] + 16'd1;
          end
        end else begin
          clr_d[0] = clr_q[0] + 16'd1;
        end
      end
      SCAN_ISSUE: begin
        state_d = SCAN_CMP;
      end
      SCAN_CMP: begin
        // Strictly-greater keeps the earliest raster position on ties.
        if (k == 16'd0 || real_gt(act_rdata, max_q)) begin
          max_d    = act_rdata;
          argmax_d = scan_idx;
        end else begin
          max_d = max_q;
        end
        if (k_last) begin
          state_d = GRAD_READ;
          phase_d = 1'b0;
        end else begin
          k_adv   = 1'b1;
          state_d = SCAN_ISSUE;
        end
      end
      GRAD_READ: begin
        if (phase_q) begin
          grad_d  = grad_rdata;
          phase_d = 1'b0;
`ifdef MAXPOOL_GRAD_ACCUM_EN
          state_d = ACC_READ;
`else
          state_d = WRITE;
`endif
        end else begin
          phase_d = 1'b1;
        end
      end
      ACC_READ: begin
        state_d = WRITE;
      end
      WRITE: begin
        out_we  = 1'b1;
`ifdef MAXPOOL_GRAD_ACCUM_EN
        out_wdata = real_add(out_rdata, grad_q);
`else
        out_wdata = grad_q;
`endif
        win_adv = 1'b1;
        if (win_last) begin
          state_d = DONE;
        end else begin
          state_d = SCAN_ISSUE;
        end
      end
      DONE: begin
        if (compute) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      clr_q    <= '0;
      argmax_q <= '0;
      max_q    <= '0;
      grad_q   <= '0;
      phase_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      clr_q    <= clr_d;
      argmax_q <= argmax_d;
      max_q    <= max_d;
      grad_q   <= grad_d;
      phase_q  <= phase_d;
      valid_q  <= (state_d == DONE);
    end
  end

endmodule
